// File: rtl/uart_byte_rx_pkg.sv
// Shared definitions for the UART byte receiver and its future TX sibling:
// default line parameters, receiver FSM encoding and the divider helper.
package uart_byte_rx_pkg;

  localparam int DEF_CLK_FREQ  = 50_000_000;
  localparam int DEF_BAUD_RATE = 115_200;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_STOP     = 3'd3,
    ST_BRK_WAIT = 3'd4
  } rx_state_e;

  // Clocks per bit, integer-truncated.
  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_byte_rx_if.sv
// Serial line plus received-byte bus of the UART receiver.
// master: line driver / byte consumer side; slave: the receiver itself.
interface uart_byte_rx_if;
  logic       uart_rxd;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_frame_err;
  logic       rx_busy;

  modport master (
    output uart_rxd,
    input  rx_data,
    input  rx_done,
    input  rx_frame_err,
    input  rx_busy
  );

  modport slave (
    input  uart_rxd,
    output rx_data,
    output rx_done,
    output rx_frame_err,
    output rx_busy
  );
endinterface

// File: rtl/uart_byte_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value selectable
// so idle-high lines come out of reset in their idle state.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic ff1_q;
  logic ff2_q;

  // Metastability chain: first flop may go metastable, second resolves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1_q <= RST_VAL;
      ff2_q <= RST_VAL;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/uart_byte_rx.sv
// UART 8N1 receiver front end. Recovers bytes from the async rx line and
// presents them with a one-cycle rx_done strobe; bad stop bits produce a
// one-cycle rx_frame_err instead and the byte is dropped.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | line idle, waiting for a falling edge
//   START     | waiting to mid start bit; a high sample there is a glitch
//   DATA      | sampling 8 data bits at mid-bit, LSB first
//   STOP      | sampling the stop bit at mid-bit
//   BRK_WAIT  | stop bit was low; wait for the line to return high
module uart_byte_rx
  import uart_byte_rx_pkg::*;
#(
  parameter int CLK_FREQ  = DEF_CLK_FREQ,
  parameter int BAUD_RATE = DEF_BAUD_RATE
) (
  input logic            clk,
  input logic            rst_n,
  uart_byte_rx_if.slave  bus
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CNT_W    = $clog2(BAUD_DIV);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_DIV - 1);

  if (BAUD_DIV < 16) begin : g_div_check
    $error("uart_byte_rx: BAUD_DIV must be at least 16");
  end

  logic             rxd_sync;
  logic             rxd_s_q;
  logic             rxd_fall;

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_rxd (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.uart_rxd),
    .q_o   (rxd_sync)
  );

  // Extra flop behind the synchronizer: gives the edge detector its history
  // and is the value every mid-bit sample reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rxd_s_q <= 1'b1;
    else        rxd_s_q <= rxd_sync;
  end

  assign rxd_fall = rxd_s_q & ~rxd_sync;

  // State, counters, shift register and output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state logic. Strobes are registered so they appear the cycle after
  // the deciding sample; returning to IDLE at mid-stop-bit lets a start edge
  // right after the stop bit be caught.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rxd_fall) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          bit_idx_d = '0;
          state_d   = rxd_s_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {rxd_s_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_FULL) begin
          if (rxd_s_q) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BRK_WAIT;
          end
        end
      end
      ST_BRK_WAIT: begin
        cnt_d = '0;
        if (rxd_s_q) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  assign bus.rx_data      = data_q;
  assign bus.rx_done      = done_q;
  assign bus.rx_frame_err = ferr_q;
  assign bus.rx_busy      = (state_q != ST_IDLE);

endmodule
